// File: rtl/relm_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | relm_div_pkg                                                               |
// | Shared types, opcode encodings and default widths for relm_div_seq.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package relm_div_pkg;

    localparam int WD_DEF  = 32;
    localparam int WOP_DEF = 5;
    localparam int WC_DEF  = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIV   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_INIT  = 3'd3,
        ST_LOOP  = 3'd4,
        ST_MOD   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // All divide-family ops share op[2:0]; opb/xsel pick the variant.
    localparam logic [2:0] OP_DIVFAM = 3'b101;
    localparam logic [2:0] OP_NONE   = 3'b000;

    localparam logic [1:0] XSEL_DIV     = 2'b00;
    localparam logic [1:0] XSEL_DIVINIT = 2'b01;
    localparam logic [1:0] XSEL_DIVLOOP = 2'b10;
    localparam logic [1:0] XSEL_DIVMOD  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/relm_onehot_index.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | relm_onehot_index                                                          |
// | One-hot to binary index encoder; returns 0 for a zero input.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module relm_onehot_index #(
    parameter int W = 32
) (
    input  logic [W-1:0]         onehot,
    output logic [$clog2(W)-1:0] index
);

    // Highest set bit wins, so a stray multi-hot input still maps to its msb.
    always_comb begin
        index = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot[i]) begin
                index = ($clog2(W))'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/relm_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | relm_div_seq                                                               |
// | Sequences DIV/DIVINIT/DIVLOOP/DIVMOD on the ReLM custom datapath to        |
// | produce quotient and remainder. Macro RELM_DIV_SIGNED_EN adds signed mode. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module relm_div_seq
    import relm_div_pkg::*;
#(
    parameter int WD  = WD_DEF,
    parameter int WOP = WOP_DEF,
    parameter int WC  = WC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
`ifdef RELM_DIV_SIGNED_EN
    input  logic             req_signed,
`endif
    input  logic [WD-1:0]    req_n,
    input  logic [WD-1:0]    req_d,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WD-1:0]    resp_q,
    output logic [WD-1:0]    resp_r,
    output logic             resp_dz,
    output logic [WOP-1:0]   cu_op,
    output logic             cu_opb,
    output logic [1:0]       cu_xsel,
    output logic [WD-1:0]    cu_a,
    output logic [WD-1:0]    cu_xb,
    output logic [WC+WD-1:0] cu_cb,
    input  logic [WD-1:0]    cu_a_out,
    input  logic [WC+WD-1:0] cu_cb_out
);

    localparam int IW  = $clog2(WD);
    localparam int WCB = WC + WD;
    localparam int HW  = WC / 2;

    state_t          state, state_nx;
    logic [WD-1:0]   a_r, xb_r, q_r, r_r;
    logic [WCB-1:0]  cb_r;
    logic            dz_r;
    logic [2:0]      op_lo;
    logic [WD-1:0]   mag_n, mag_d;
    logic [WD-1:0]   b_word, n_word;
    logic [IW-1:0]   pn, pd, k;
    logic            div_zero, quick;

    // CB layout: {D word, C word, B word}; D holds the running remainder.
    assign b_word   = cb_r[WD-1:0];
    assign n_word   = WD'(cb_r[WCB-1 -: HW]);
    assign k        = pn - pd;
    assign div_zero = (xb_r == '0);
    assign quick    = (a_r == '0) || (pn < pd);

    relm_onehot_index #(.W(WD)) u_idx_n (.onehot(a_r),    .index(pn));
    relm_onehot_index #(.W(WD)) u_idx_d (.onehot(b_word), .index(pd));

`ifdef RELM_DIV_SIGNED_EN
    logic neg_n, neg_d, sgn_n, sgn_d;

    assign sgn_n = req_signed & req_n[WD-1];
    assign sgn_d = req_signed & req_d[WD-1];
    assign mag_n = sgn_n ? -req_n : req_n;
    assign mag_d = sgn_d ? -req_d : req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_n <= 1'b0;
            neg_d <= 1'b0;
        end else if (state == ST_IDLE && req_valid) begin
            neg_n <= sgn_n;
            neg_d <= sgn_d;
        end
    end

    // A zero divisor is never negative, so the dz result (all-ones, |N|)
    // turns into -1/+1 and R=N through the same sign fix-up.
    assign resp_q = (neg_n ^ neg_d) ? -q_r : q_r;
    assign resp_r = neg_n ? -r_r : r_r;
`else
    assign mag_n  = req_n;
    assign mag_d  = req_d;
    assign resp_q = q_r;
    assign resp_r = r_r;
`endif

    assign resp_dz = dz_r;
    assign cu_a    = a_r;
    assign cu_xb   = xb_r;
    assign cu_cb   = cb_r;
    assign cu_op   = WOP'(op_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        op_lo      = OP_NONE;
        cu_opb     = 1'b0;
        cu_xsel    = XSEL_DIV;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ST_DIV;
            end
            ST_DIV: begin
                op_lo    = OP_DIVFAM;
                state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                state_nx = (div_zero || quick) ? ST_DONE : ST_INIT;
            end
            ST_INIT: begin
                op_lo    = OP_DIVFAM;
                cu_opb   = 1'b1;
                cu_xsel  = XSEL_DIVINIT;
                state_nx = ST_LOOP;
            end
            ST_LOOP: begin
                op_lo   = OP_DIVFAM;
                cu_opb  = 1'b1;
                cu_xsel = XSEL_DIVLOOP;
                if (cu_a_out == '0) state_nx = ST_MOD;
            end
            ST_MOD: begin
                op_lo    = OP_DIVFAM;
                cu_opb   = 1'b1;
                cu_xsel  = XSEL_DIVMOD;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            xb_r <= '0;
            cb_r <= '0;
            q_r  <= '0;
            r_r  <= '0;
            dz_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_r  <= mag_n;
                        xb_r <= mag_d;
                        dz_r <= 1'b0;
                    end
                end
                ST_DIV, ST_INIT, ST_LOOP: begin
                    a_r  <= cu_a_out;
                    cb_r <= cu_cb_out;
                end
                ST_SHIFT: begin
                    if (div_zero) begin
                        q_r  <= '1;
                        r_r  <= n_word;
                        dz_r <= 1'b1;
                    end else if (quick) begin
                        q_r <= '0;
                        r_r <= n_word;
                    end else begin
                        a_r <= WD'(1) << k;
                    end
                end
                ST_MOD: begin
                    q_r <= cu_cb_out[WD-1:0];
                    r_r <= cu_a_out;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/relm_div_seq.md
# relm_div_seq

Multi-cycle sequencer for the integer-divide path of the ReLM custom datapath (DIV, DIVINIT, DIVLOOP, DIVMOD opcodes).
- Accepts a dividend/divisor pair over a valid/ready handshake.
- Issues the opcode sequence to the custom unit, one op per cycle, and holds the A and CB operand registers between ops.
- Returns quotient and remainder.
- Sits between the ReLM core's custom-instruction issue stage and the shared custom datapath.

## Interface
Parameters:
- WD, 32, data width.
- WOP, 5, opcode width; x-field select bits sit at WOP+1:WOP.
- WC, 64, width of the CB extension (D and C words).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  division request.
- req_ready  out  1  high only in IDLE.
- req_n  in  WD  dividend N.
- req_d  in  WD  divisor D.
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumed.
- resp_q  out  WD  quotient.
- resp_r  out  WD  remainder.
- resp_dz  out  1  divide-by-zero flag.
- cu_op  out  WOP  custom-unit opcode; low 3 bits = 3'b101.
- cu_opb  out  1  OPB select.
- cu_xsel  out  2  drives x_in[WOP+1:WOP].
- cu_a  out  WD  A operand.
- cu_xb  out  WD  XB operand.
- cu_cb  out  WC+WD  CB operand.
- cu_a_out  in  WD  custom-unit A result (combinational).
- cu_cb_out  in  WC+WD  custom-unit CB result (combinational).

## Operation
FSM states: IDLE, DIV, SHIFT, INIT, LOOP, MOD, DONE.

- **IDLE**
  - req_ready=1.
  - On req_valid, capture N into A and D into XB, then go to DIV.
- **DIV**
  - Drive opb=0, op=DIV.
  - Capture cu_a_out (one-hot msb of N, n) into A and cu_cb_out into CB (D=N, C=D, B=d).
  - Go to SHIFT.
- **SHIFT**
  - Compute pn = index(n) and pd = index(d); k = pn - pd.
  - If D==0: Q=all-ones, R=N, dz=1, go to DONE.
  - Else if n==0 or pn<pd: Q=0, R=N, go to DONE.
  - Else A = 1<<k, go to INIT.
- **INIT**
  - Drive opb=1, xsel=01 (DIVINIT).
  - Capture A and CB (C becomes D*q, B becomes 0).
- **LOOP**
  - Drive opb=1, xsel=10 (DIVLOOP) every cycle, capturing A and CB.
  - Exit to MOD on the cycle the captured A becomes 0.
  - L = floor(k/2)+1 iterations.
- **MOD**
  - Drive opb=1, xsel=11 (DIVMOD).
  - Q = B word of cu_cb_out; R = cu_a_out.
- **DONE**
  - resp_valid=1, with resp_q, resp_r and resp_dz held stable.
  - On resp_ready, go to IDLE.

Operand and arithmetic rules:
- cu_a, cu_xb and cu_cb are the sequencer registers, driven unchanged during the op.
- In IDLE and DONE, cu_op low bits = 3'b000 and cu_opb = 0.
- All arithmetic is unsigned modulo 2^WD, and k is in 0..WD-1.
- The index() priority encoder returns 0 for a zero input.

## Timing
- Let t0 be the accept cycle. Then:
  - DIV at t0+1, SHIFT at t0+2, INIT at t0+3.
  - LOOP at t0+4 .. t0+3+L, MOD at t0+4+L.
  - resp_valid rises at t0+5+L.
- Fast paths (D==0, N<D, N==0): resp_valid rises at t0+3.
- A new request cannot be accepted before the cycle after a resp handshake.
- Back-to-back throughput is therefore one division per latency+1 cycles.
- resp_ready held low stalls in DONE indefinitely; outputs stay stable.
- Reset values, applied asynchronously whenever rst_n=0:
  - State = IDLE.
  - All registers and outputs = 0, except req_ready=1.
- Reset mid-operation: the current division is abandoned and no response is produced.

## Configuration
Macro: RELM_DIV_SIGNED_EN.

Defined:
- Adds input req_signed.
- When req_signed=1:
  - Operands are converted to magnitudes on capture.
  - resp_q is negated if the operand signs differ.
  - resp_r takes the sign of N.
- These conversions are combinational at capture and output, and add no cycles.
- Signed D==0: Q=-1 if N≥0, else +1; R=N.

Undefined:
- Unsigned only.
- The req_signed port is absent.

## Structure
- Package relm_div_pkg holds:
  - State enum.
  - The DIV/DIVINIT/DIVLOOP/DIVMOD encodings: op[2:0]=3'b101, and xsel 00/01/10/11 with opb.
  - Default widths.
- One sub-module, relm_onehot_index: WD-bit one-hot to log2(WD)-bit index, used twice in SHIFT.

## Test plan
- N=100, D=7 → Q=14, R=2, dz=0.
  - k=4, L=3, resp_valid at t0+8.
  - cu_op/xsel trace is DIV, INIT, LOOP×3, MOD.
- N=0xFFFFFFFF, D=1 → Q=0xFFFFFFFF, R=0; k=31, L=16, resp_valid at t0+21.
- N=5, D=9 → Q=0, R=5; resp_valid at t0+3, with no INIT/LOOP ops issued.
- N=42, D=0 → Q=0xFFFFFFFF, R=42, dz=1 at t0+3.
- resp_ready held low 10 cycles → outputs stable and req_ready=0 throughout.
  - rst_n pulsed low during LOOP → immediate IDLE, req_ready=1, no resp_valid.
- RELM_DIV_SIGNED_EN: N=-100, D=7, signed → Q=-14, R=-2.
  - N=100, D=-7 → Q=-14, R=2.
